spi_master: RTL and testbench

- Single-channel SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, one chip select.
- Generates sclk, cs and mosi from the system clock. Shifts in miso. Presents one received word per transfer.
- Forms the initiator end of the SPI link. Drives our SPI slave blocks and the bench slave models.
- Host side uses a start/busy/done handshake driven from on-chip control logic.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_sclk_div.sv | 28 ++
 rtl/spi_master.sv | 152 +++++++++++++++
 tb/tb_spi_master.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI definitions: FSM state encoding and link mode constants
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } spi_state_t;

    localparam bit SPI_CPOL      = 1'b0;
    localparam bit SPI_CPHA      = 1'b0;
    localparam bit SPI_MSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_sclk_div.sv
// rtl/spi_sclk_div.sv - half-period tick generator; tick fires as the count wraps at CLK_DIV-1
module spi_sclk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode 0, MSB-first SPI master with start/busy/done host handshake
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              cs,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W);

    spi_state_t state, state_next;

    logic              tick;
    logic              div_clr;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [BW-1:0]     bit_cnt;
    logic              load;
    logic              rise;
    logic              fall;
    logic              release_cs;
    logic              finish;

    // Every non-IDLE transition happens on a tick, so the wrap itself clears the
    // divider on state entry; holding it clear in IDLE covers the IDLE->SETUP entry.
    spi_sclk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (div_clr),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        div_clr    = 1'b0;
        load       = 1'b0;
        rise       = 1'b0;
        fall       = 1'b0;
        release_cs = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                div_clr = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                if (tick) begin
                    if (!sclk) begin
                        rise = 1'b1;
                    end else begin
                        fall = 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state_next = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    release_cs = 1'b1;
                    state_next = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs      <= 1'b1;
            sclk    <= SPI_CPOL;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
        end else begin
            done <= finish;
            if (load) begin
                tx_sh   <= tx_data;
                mosi    <= tx_data[DATA_W-1];
                cs      <= 1'b0;
                busy    <= 1'b1;
                rx_sh   <= '0;
                bit_cnt <= '0;
            end
            if (rise) begin
                sclk    <= 1'b1;
                rx_sh   <= {rx_sh[DATA_W-2:0], miso};
                bit_cnt <= bit_cnt + 1'b1;
            end
            // The last falling edge leaves mosi on the LSB until cs releases.
            if (fall) begin
                sclk <= 1'b0;
                if (bit_cnt != LAST_BIT) begin
                    tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                    mosi  <= tx_sh[DATA_W-2];
                end
            end
            if (release_cs) begin
                cs   <= 1'b1;
                mosi <= 1'b0;
            end
            if (finish) begin
                rx_data <= rx_sh;
                busy    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master at 8b/div2 and 16b/div1
module tb_spi_master;

    localparam int AW  = 8;
    localparam int AD  = 2;
    localparam int BWD = 16;
    localparam int BD  = 1;
    localparam int P   = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #(P/2) clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- instance A: 8 bits, CLK_DIV=2 ----------------
    logic           a_start = 1'b0;
    logic [AW-1:0]  a_tx    = '0;
    logic           a_busy, a_done, a_cs, a_sclk, a_mosi;
    logic           a_miso  = 1'b0;
    logic [AW-1:0]  a_rx;

    spi_master #(.DATA_W(AW), .CLK_DIV(AD)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .tx_data(a_tx),
        .busy(a_busy), .done(a_done), .rx_data(a_rx),
        .cs(a_cs), .sclk(a_sclk), .mosi(a_mosi), .miso(a_miso)
    );

    logic [AW-1:0] a_slv_q[$];
    logic [AW-1:0] a_exp_tx[$];
    logic [AW-1:0] a_exp_rx[$];
    logic [AW-1:0] a_slv_sh = '0;
    logic [AW-1:0] a_cap    = '0;
    int            a_rises  = 0;
    int            a_dones  = 0;
    int            a_lat    = 0;
    time           a_t_csf  = 0;
    time           a_t_csr  = 0;
    logic          a_csr_seen = 1'b0;
    logic          a_pd = 1'b0, a_pb = 1'b0;

    // Slave model: presents MSB at cs fall, next bit on each sclk fall, captures mosi on rise.
    always @(negedge a_cs) begin
        a_slv_sh = '0;
        if (a_slv_q.size() > 0) a_slv_sh = a_slv_q.pop_front();
        a_miso  = a_slv_sh[AW-1];
        a_rises = 0;
        a_cap   = '0;
        a_t_csf = $time;
        if (a_csr_seen) chk("a_cs_high_time", 32'(($time - a_t_csr) / P >= AD), 32'(1));
    end
    always @(posedge a_cs) begin
        a_t_csr    = $time;
        a_csr_seen = 1'b1;
    end
    always @(posedge a_sclk) begin
        a_cap = {a_cap[AW-2:0], a_mosi};
        a_rises++;
    end
    always @(negedge a_sclk) begin
        if (a_cs === 1'b0) begin
            a_slv_sh = a_slv_sh << 1;
            a_miso   = a_slv_sh[AW-1];
        end
    end
    always @(posedge a_done) a_lat = int'(($time - a_t_csf) / P);

    always @(negedge clk) begin
        if (!rst_n) begin
            a_pd = 1'b0;
            a_pb = 1'b0;
        end else begin
            if (a_done) begin
                a_dones++;
                chk("a_done_one_cycle", 32'(a_pd), 32'(0));
                chk("a_busy_low_at_done", 32'(a_busy), 32'(0));
                chk("a_done_expected", 32'(a_exp_rx.size() != 0), 32'(1));
                if (a_exp_rx.size() != 0) begin
                    chk("a_rx_data", 32'(a_rx), 32'(a_exp_rx.pop_front()));
                    chk("a_mosi_word", 32'(a_cap), 32'(a_exp_tx.pop_front()));
                    chk("a_sclk_rises", 32'(a_rises), 32'(AW));
                    chk("a_latency", 32'(a_lat), 32'((2 * AW + 3) * AD));
                end
            end
            if (a_pb && !a_busy) chk("a_busy_until_done", 32'(a_done), 32'(1));
            a_pd = a_done;
            a_pb = a_busy;
        end
    end

    task automatic a_wait_idle();
        int i = 0;
        while (a_busy && i < 300) begin
            cyc(1);
            i++;
        end
        chk("a_wait_idle", 32'(a_busy), 32'(0));
    endtask

    task automatic a_issue(input logic [AW-1:0] tx, input logic [AW-1:0] sw);
        a_wait_idle();
        a_slv_q.push_back(sw);
        a_exp_tx.push_back(tx);
        a_exp_rx.push_back(sw);
        a_start = 1'b1;
        a_tx    = tx;
        cyc(1);
        a_start = 1'b0;
    endtask

    task automatic a_wait_done();
        int i = 0;
        while (!a_done && i < 300) begin
            cyc(1);
            i++;
        end
        chk("a_done_timeout", 32'(a_done), 32'(1));
        cyc(1);
    endtask

    // ---------------- instance B: 16 bits, CLK_DIV=1 ----------------
    logic            b_start = 1'b0;
    logic [BWD-1:0]  b_tx    = '0;
    logic            b_busy, b_done, b_cs, b_sclk, b_mosi;
    logic            b_miso  = 1'b0;
    logic [BWD-1:0]  b_rx;

    spi_master #(.DATA_W(BWD), .CLK_DIV(BD)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .tx_data(b_tx),
        .busy(b_busy), .done(b_done), .rx_data(b_rx),
        .cs(b_cs), .sclk(b_sclk), .mosi(b_mosi), .miso(b_miso)
    );

    logic [BWD-1:0] b_slv_q[$];
    logic [BWD-1:0] b_exp_tx[$];
    logic [BWD-1:0] b_exp_rx[$];
    logic [BWD-1:0] b_slv_sh = '0;
    logic [BWD-1:0] b_cap    = '0;
    int             b_rises  = 0;
    int             b_lat    = 0;
    time            b_t_csf  = 0;
    time            b_t_rise = 0;

    always @(negedge b_cs) begin
        b_slv_sh = '0;
        if (b_slv_q.size() > 0) b_slv_sh = b_slv_q.pop_front();
        b_miso  = b_slv_sh[BWD-1];
        b_rises = 0;
        b_cap   = '0;
        b_t_csf = $time;
    end
    always @(posedge b_sclk) begin
        if (b_rises > 0) chk("b_sclk_period", 32'(($time - b_t_rise) / P), 32'(2 * BD));
        b_t_rise = $time;
        b_cap    = {b_cap[BWD-2:0], b_mosi};
        b_rises++;
    end
    always @(negedge b_sclk) begin
        if (b_cs === 1'b0) begin
            b_slv_sh = b_slv_sh << 1;
            b_miso   = b_slv_sh[BWD-1];
        end
    end
    always @(posedge b_done) b_lat = int'(($time - b_t_csf) / P);

    always @(negedge clk) begin
        if (rst_n && b_done) begin
            chk("b_done_expected", 32'(b_exp_rx.size() != 0), 32'(1));
            if (b_exp_rx.size() != 0) begin
                chk("b_rx_data", 32'(b_rx), 32'(b_exp_rx.pop_front()));
                chk("b_mosi_word", 32'(b_cap), 32'(b_exp_tx.pop_front()));
                chk("b_sclk_rises", 32'(b_rises), 32'(BWD));
                chk("b_latency", 32'(b_lat), 32'((2 * BWD + 3) * BD));
            end
        end
    end

    task automatic b_xfer(input logic [BWD-1:0] tx, input logic [BWD-1:0] sw);
        int i = 0;
        while (b_busy && i < 300) begin
            cyc(1);
            i++;
        end
        b_slv_q.push_back(sw);
        b_exp_tx.push_back(tx);
        b_exp_rx.push_back(sw);
        b_start = 1'b1;
        b_tx    = tx;
        cyc(1);
        b_start = 1'b0;
        i = 0;
        while (!b_done && i < 300) begin
            cyc(1);
            i++;
        end
        chk("b_done_timeout", 32'(b_done), 32'(1));
        cyc(1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #(P * 20000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int            bad;
        int            d0;
        logic [AW-1:0] w1, w2, tx, sw;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_cs", 32'(a_cs), 32'(1));
        chk("rst_sclk", 32'(a_sclk), 32'(0));
        chk("rst_mosi", 32'(a_mosi), 32'(0));
        chk("rst_busy", 32'(a_busy), 32'(0));
        chk("rst_done", 32'(a_done), 32'(0));
        chk("rst_rx", 32'(a_rx), 32'(0));
        chk("rst_b_cs", 32'(b_cs), 32'(1));
        cyc(3);
        rst_n = 1'b1;
        cyc(1);

        bad = 0;
        repeat (100) begin
            cyc(1);
            if (a_cs !== 1'b1 || a_sclk !== 1'b0 || a_mosi !== 1'b0 || a_done !== 1'b0) bad++;
        end
        chk("idle_outputs", 32'(bad), 32'(0));

        a_issue(8'hA5, 8'h3C);
        a_wait_done();
        chk("loopback_rx", 32'(a_rx), 32'(8'h3C));

        // Back-to-back with start held high throughout
        w1 = AW'($urandom());
        w2 = AW'($urandom());
        a_slv_q.push_back(w1); a_exp_tx.push_back(8'h01); a_exp_rx.push_back(w1);
        a_slv_q.push_back(w2); a_exp_tx.push_back(8'hFE); a_exp_rx.push_back(w2);
        d0 = a_dones;
        a_start = 1'b1;
        a_tx    = 8'h01;
        cyc(1);
        a_tx = 8'hFE;
        a_wait_idle();
        cyc(1);
        a_start = 1'b0;
        chk("b2b_second_accepted", 32'(a_busy), 32'(1));
        a_wait_done();
        cyc(10);
        chk("b2b_done_count", 32'(a_dones - d0), 32'(2));

        repeat (6) begin
            a_issue(AW'($urandom()), AW'($urandom()));
            a_wait_done();
        end

        // Start pulses and tx_data churn while busy must not disturb or queue
        tx = AW'($urandom());
        sw = AW'($urandom()) | 8'h01;
        a_issue(tx, sw);
        d0 = a_dones;
        for (int k = 0; k < 6; k++) begin
            cyc(int'($urandom_range(1, 4)));
            a_start = 1'b1;
            a_tx    = AW'($urandom());
            cyc(1);
            a_start = 1'b0;
        end
        chk("busy_held_mid_xfer", 32'(a_busy), 32'(1));
        a_wait_done();
        bad = 0;
        repeat (20) begin
            cyc(1);
            if (a_cs !== 1'b1 || a_busy !== 1'b0) bad++;
        end
        chk("no_queued_xfer", 32'(bad), 32'(0));
        chk("ignore_done_count", 32'(a_dones - d0), 32'(1));

        // Abort by reset after three rising sclk edges
        a_slv_q.push_back(AW'($urandom()));
        a_start = 1'b1;
        a_tx    = AW'($urandom());
        cyc(1);
        a_start = 1'b0;
        bad = 0;
        while (a_rises < 3 && bad < 200) begin
            cyc(1);
            bad++;
        end
        chk("abort_reached_3_rises", 32'(a_rises), 32'(3));
        d0 = a_dones;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs", 32'(a_cs), 32'(1));
        chk("abort_sclk", 32'(a_sclk), 32'(0));
        chk("abort_busy", 32'(a_busy), 32'(0));
        chk("abort_rx_cleared", 32'(a_rx), 32'(0));
        cyc(3);
        rst_n = 1'b1;
        cyc(10);
        chk("abort_no_done", 32'(a_dones - d0), 32'(0));
        sw = AW'($urandom());
        a_issue(8'h55, sw);
        a_wait_done();
        chk("after_abort_rx", 32'(a_rx), 32'(sw));

        b_xfer(16'h8001, 16'hC3C3);
        chk("b_rx_c3c3", 32'(b_rx), 32'(16'hC3C3));
        repeat (3) b_xfer(BWD'($urandom()), BWD'($urandom()));

        cyc(5);
        chk("a_scoreboard_drained", 32'(a_exp_rx.size()), 32'(0));
        chk("b_scoreboard_drained", 32'(b_exp_rx.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
